// File: rtl/pll_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | pll_pkg : shared encodings and gain defaults for the PLL     |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
package pll_pkg;

  localparam int c_shift_w = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_GEAR  = 2'd2,
    ST_TRACK = 2'd3
  } state_t;

  localparam int c_kp_acq_def = 12;
  localparam int c_ki_acq_def = 8;
  localparam int c_kp_trk_def = 8;
  localparam int c_ki_trk_def = 2;

endpackage
`default_nettype wire

// File: rtl/pll_sample_divider.sv
`default_nettype none
// +--------------------------------------------------------------+
// | pll_sample_divider : programmable down-counter, 1-clk strobe |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module pll_sample_divider #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_strobe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else if (load) begin
      r_cnt    <= div;
      r_strobe <= 1'b0;
    end else if (run) begin
      if (r_cnt == '0) begin
        r_cnt    <= div;
        r_strobe <= 1'b1;
      end else begin
        r_cnt    <= r_cnt - DIV_W'(1);
        r_strobe <= 1'b0;
      end
    end else begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end
  end

  assign strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/pll_gain_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------+
// | pll_gain_scheduler : loop-filter gain sequencer ACQ->TRACK   |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module pll_gain_scheduler
  import pll_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int CNT_W    = 16,
  parameter int KP_ACQ   = c_kp_acq_def,
  parameter int KI_ACQ   = c_ki_acq_def,
  parameter int KP_TRK   = c_kp_trk_def,
  parameter int KI_TRK   = c_ki_trk_def,
  parameter int LOSS_LIM = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_W-1:0]     sample_div,
  input  logic [CNT_W-1:0]     dwell_len,
  input  logic [CNT_W-1:0]     timeout_len,
  input  logic                 lock_in,
  input  logic                 clear_err,
  output logic                 sample_en,
  output logic [c_shift_w-1:0] kp_shift,
  output logic [c_shift_w-1:0] ki_shift,
  output logic                 filter_rst_n,
  output logic [1:0]           state,
  output logic                 locked,
  output logic                 timeout_err
);

  localparam logic [c_shift_w-1:0] c_kp_acq   = c_shift_w'(KP_ACQ);
  localparam logic [c_shift_w-1:0] c_ki_acq   = c_shift_w'(KI_ACQ);
  localparam logic [c_shift_w-1:0] c_kp_trk   = c_shift_w'(KP_TRK);
  localparam logic [c_shift_w-1:0] c_ki_trk   = c_shift_w'(KI_TRK);
  localparam logic [CNT_W:0]       c_loss_lim = (CNT_W+1)'(LOSS_LIM);

  state_t               r_state;
  logic [c_shift_w-1:0] r_kp, r_ki;
  logic [CNT_W-1:0]     r_dwell, r_to, r_loss;
  logic                 r_frst, r_locked, r_err;
  logic                 w_sample;

  pll_sample_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (enable && (r_state != ST_IDLE)),
    .load   (enable && (r_state == ST_IDLE)),
    .div    (sample_div),
    .strobe (w_sample)
  );

  // One extra bit so the "+1 reaches limit" compares never wrap.
  logic [CNT_W:0]       w_dwell_p1, w_to_p1, w_loss_p1, w_dwell_len;
  logic [CNT_W-1:0]     w_dwell_inc, w_to_inc, w_loss_inc;
  logic [c_shift_w-1:0] w_kp_dn, w_ki_dn;
  logic                 w_dwell_done, w_to_done, w_loss_done, w_at_trk, w_set_err;

  assign w_dwell_p1   = {1'b0, r_dwell} + (CNT_W+1)'(1);
  assign w_to_p1      = {1'b0, r_to}    + (CNT_W+1)'(1);
  assign w_loss_p1    = {1'b0, r_loss}  + (CNT_W+1)'(1);
  assign w_dwell_inc  = (&r_dwell) ? r_dwell : w_dwell_p1[CNT_W-1:0];
  assign w_to_inc     = (&r_to)    ? r_to    : w_to_p1[CNT_W-1:0];
  assign w_loss_inc   = (&r_loss)  ? r_loss  : w_loss_p1[CNT_W-1:0];
  assign w_dwell_len  = (dwell_len == '0) ? (CNT_W+1)'(1) : {1'b0, dwell_len};
  assign w_dwell_done = lock_in && (w_dwell_p1 >= w_dwell_len);
  assign w_to_done    = (timeout_len != '0) && (w_to_p1 >= {1'b0, timeout_len});
  assign w_loss_done  = !lock_in && (w_loss_p1 >= c_loss_lim);
  assign w_at_trk     = (r_kp == c_kp_trk) && (r_ki == c_ki_trk);
  assign w_kp_dn      = (r_kp > c_kp_trk) ? r_kp - c_shift_w'(1) : r_kp;
  assign w_ki_dn      = (r_ki > c_ki_trk) ? r_ki - c_shift_w'(1) : r_ki;
  assign w_set_err    = enable && (r_state == ST_ACQ) && w_sample
                        && !w_dwell_done && w_to_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_kp     <= c_kp_acq;
      r_ki     <= c_ki_acq;
      r_dwell  <= '0;
      r_to     <= '0;
      r_loss   <= '0;
      r_frst   <= 1'b0;
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_set_err)      r_err <= 1'b1;
      else if (clear_err) r_err <= 1'b0;

      if (!enable) begin
        r_state  <= ST_IDLE;
        r_kp     <= c_kp_acq;
        r_ki     <= c_ki_acq;
        r_dwell  <= '0;
        r_to     <= '0;
        r_loss   <= '0;
        r_frst   <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ACQ;
            r_frst  <= 1'b1;
          end
          ST_ACQ: begin
            r_frst <= 1'b1;
            if (w_sample) begin
              if (w_dwell_done) begin
                r_dwell <= '0;
                r_to    <= '0;
                if (w_at_trk) begin
                  r_state  <= ST_TRACK;
                  r_locked <= 1'b1;
                end else begin
                  r_kp    <= w_kp_dn;
                  r_ki    <= w_ki_dn;
                  r_state <= ST_GEAR;
                end
              end else if (w_to_done) begin
                // Kick the loop filter back to a clean start and retry.
                r_frst  <= 1'b0;
                r_dwell <= '0;
                r_to    <= '0;
              end else begin
                r_dwell <= lock_in ? w_dwell_inc : '0;
                r_to    <= w_to_inc;
              end
            end
          end
          default: begin
            if (w_sample) begin
              if (!lock_in) begin
                r_dwell <= '0;
                if (w_loss_done) begin
                  r_state  <= ST_ACQ;
                  r_kp     <= c_kp_acq;
                  r_ki     <= c_ki_acq;
                  r_to     <= '0;
                  r_loss   <= '0;
                  r_locked <= 1'b0;
                end else begin
                  r_loss <= w_loss_inc;
                end
              end else begin
                r_loss <= '0;
                if (r_state == ST_GEAR) begin
                  if (w_dwell_done) begin
                    r_dwell <= '0;
                    if (w_at_trk) begin
                      r_state  <= ST_TRACK;
                      r_locked <= 1'b1;
                    end else begin
                      r_kp <= w_kp_dn;
                      r_ki <= w_ki_dn;
                    end
                  end else begin
                    r_dwell <= w_dwell_inc;
                  end
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign sample_en    = w_sample;
  assign kp_shift     = r_kp;
  assign ki_shift     = r_ki;
  assign filter_rst_n = r_frst;
  assign state        = r_state;
  assign locked       = r_locked;
  assign timeout_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pll_gain_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_pll_gain_scheduler : bench with behavioural gain model    |
// | Rev 1.0                                                      |
// +--------------------------------------------------------------+
module tb_pll_gain_scheduler;

  localparam int KP_A = 12, KI_A = 8, KP_T = 8, KI_T = 2, LOSS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  sample_div = 8'd3;
  logic [15:0] dwell_len = 16'd2;
  logic [15:0] timeout_len = 16'd0;
  logic        lock_in = 1'b0;
  logic        clear_err = 1'b0;
  logic        sample_en, filter_rst_n, locked, timeout_err;
  logic [4:0]  kp_shift, ki_shift;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  pll_gain_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_div(sample_div),
    .dwell_len(dwell_len), .timeout_len(timeout_len), .lock_in(lock_in),
    .clear_err(clear_err), .sample_en(sample_en), .kp_shift(kp_shift),
    .ki_shift(ki_shift), .filter_rst_n(filter_rst_n), .state(state),
    .locked(locked), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: gains derived from a step count, sampling from a
  // clocks-since-last-strobe phase counter.
  int m_state = 0, m_ph = 0, m_steps = 0, m_dwell = 0, m_to = 0, m_loss = 0;
  bit m_se = 0, m_frst = 0, m_locked = 0, m_err = 0;

  function automatic int gain(input int acq, input int trk, input int steps);
    return (acq - steps > trk) ? acq - steps : trk;
  endfunction

  task automatic m_dwell_complete();
    if (gain(KP_A, KP_T, m_steps) == KP_T && gain(KI_A, KI_T, m_steps) == KI_T) begin
      m_state = 3; m_locked = 1;
    end else begin
      m_steps++; m_state = 2;
    end
    m_dwell = 0; m_to = 0;
  endtask

  task automatic model_tick();
    bit smp, setv;
    int dlen;
    if (!rst_n) begin
      m_state = 0; m_ph = 0; m_steps = 0; m_dwell = 0; m_to = 0; m_loss = 0;
      m_se = 0; m_frst = 0; m_locked = 0; m_err = 0;
      return;
    end
    smp  = m_se;
    setv = 0;
    dlen = (dwell_len == 0) ? 1 : int'(dwell_len);
    if (!enable) begin
      m_state = 0; m_ph = 0; m_steps = 0; m_dwell = 0; m_to = 0; m_loss = 0;
      m_se = 0; m_frst = 0; m_locked = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_frst = 1; m_ph = 0; m_se = 0;
    end else begin
      m_ph++;
      if (m_ph > int'(sample_div)) begin m_se = 1; m_ph = 0; end
      else m_se = 0;
      if (m_state == 1) begin
        m_frst = 1;
        if (smp) begin
          m_dwell = lock_in ? m_dwell + 1 : 0;
          m_to++;
          if (lock_in && m_dwell >= dlen) m_dwell_complete();
          else if (timeout_len != 0 && m_to >= int'(timeout_len)) begin
            setv = 1; m_frst = 0; m_dwell = 0; m_to = 0;
          end
        end
      end else if (smp) begin
        if (!lock_in) begin
          m_dwell = 0; m_loss++;
          if (m_loss >= LOSS) begin
            m_state = 1; m_steps = 0; m_to = 0; m_loss = 0; m_locked = 0;
          end
        end else begin
          m_loss = 0;
          if (m_state == 2) begin
            m_dwell++;
            if (m_dwell >= dlen) m_dwell_complete();
          end
        end
      end
    end
    if (setv) m_err = 1;
    else if (clear_err) m_err = 0;
  endtask

  always @(posedge clk or negedge rst_n) model_tick();

  always @(negedge clk) begin
    chk("model_sample_en", int'(sample_en), int'(m_se));
    chk("model_state", int'(state), m_state);
    chk("model_kp", int'(kp_shift), gain(KP_A, KP_T, m_steps));
    chk("model_ki", int'(ki_shift), gain(KI_A, KI_T, m_steps));
    chk("model_filter_rst_n", int'(filter_rst_n), int'(m_frst));
    chk("model_locked", int'(locked), int'(m_locked));
    chk("model_timeout_err", int'(timeout_err), int'(m_err));
  end

  // Wait for the next sample and let its clock edge consume it.
  task automatic do_sample(input bit lk);
    int k;
    lock_in = lk;
    k = 0;
    while (sample_en !== 1'b1 && k < 300) begin
      @(negedge clk); k++;
    end
    if (k >= 300) begin
      chk("sample_wait_timeout", k, 0);
      return;
    end
    @(negedge clk);
  endtask

  task automatic measure_gap(input int exp);
    int k;
    k = 0;
    do begin
      @(negedge clk); k++;
    end while (sample_en !== 1'b1 && k < 50);
    chk("sample_gap", k, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sample_en"}, int'(sample_en), 0);
    chk({tag, "_kp"}, int'(kp_shift), KP_A);
    chk({tag, "_ki"}, int'(ki_shift), KI_A);
    chk({tag, "_filter_rst_n"}, int'(filter_rst_n), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  typedef struct {
    bit lk;
    int n;
    int st;
    int kp;
    int ki;
    bit lck;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 2, 2, 11, 7, 0};
    tbl[1] = '{1, 2, 2, 10, 6, 0};
    tbl[2] = '{1, 2, 2,  9, 5, 0};
    tbl[3] = '{1, 2, 2,  8, 4, 0};
    tbl[4] = '{1, 2, 2,  8, 3, 0};
    tbl[5] = '{1, 2, 2,  8, 2, 0};
    tbl[6] = '{1, 2, 3,  8, 2, 1};
    tbl[7] = '{0, 3, 3,  8, 2, 1};
    tbl[8] = '{1, 1, 3,  8, 2, 1};
    tbl[9] = '{0, 4, 1, 12, 8, 0};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // ACQ entry and sample spacing with sample_div=3.
    enable = 1'b1;
    @(negedge clk);
    chk("acq_state", int'(state), 1);
    chk("acq_filter_rst_n", int'(filter_rst_n), 1);
    chk("acq_kp", int'(kp_shift), 12);
    chk("acq_ki", int'(ki_shift), 8);
    measure_gap(4);
    measure_gap(4);

    // Gear-down, TRACK, tolerated loss, real loss.
    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s < tbl[r].n; s++) do_sample(tbl[r].lk);
      chk($sformatf("tbl%0d_state", r), int'(state), tbl[r].st);
      chk($sformatf("tbl%0d_kp", r), int'(kp_shift), tbl[r].kp);
      chk($sformatf("tbl%0d_ki", r), int'(ki_shift), tbl[r].ki);
      chk($sformatf("tbl%0d_locked", r), int'(locked), int'(tbl[r].lck));
    end

    // Enable dropped mid-GEAR, then restart timing.
    do_sample(1); do_sample(1);
    chk("gear_state", int'(state), 2);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_state", int'(state), 0);
    chk("drop_sample_en", int'(sample_en), 0);
    chk("drop_filter_rst_n", int'(filter_rst_n), 0);
    chk("drop_kp", int'(kp_shift), 12);
    chk("drop_ki", int'(ki_shift), 8);
    enable = 1'b1;
    @(negedge clk);
    measure_gap(4);

    // Acquisition timeout with lock never seen.
    enable = 1'b0; lock_in = 1'b0;
    @(negedge clk);
    timeout_len = 16'd5;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    repeat (4) do_sample(0);
    chk("to_err_early", int'(timeout_err), 0);
    do_sample(0);
    chk("to_err_set", int'(timeout_err), 1);
    chk("to_frst_low", int'(filter_rst_n), 0);
    @(negedge clk);
    chk("to_frst_back", int'(filter_rst_n), 1);
    clear_err = 1'b1;
    @(negedge clk);
    chk("to_err_cleared", int'(timeout_err), 0);
    repeat (4) do_sample(0);
    do_sample(0);
    chk("to_set_beats_clear", int'(timeout_err), 1);
    @(negedge clk);
    chk("to_clear_after", int'(timeout_err), 0);
    clear_err = 1'b0;

    // dwell_len=0 acts as 1, sample_div=0 strobes every clock.
    enable = 1'b0;
    @(negedge clk);
    sample_div = 8'd0; dwell_len = 16'd0; timeout_len = 16'd0;
    @(negedge clk);
    enable = 1'b1;
    repeat (7) do_sample(1);
    chk("fast_state", int'(state), 3);
    chk("fast_locked", int'(locked), 1);
    for (int i = 0; i < 3; i++) begin
      chk("fast_sample_en", int'(sample_en), 1);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    @(negedge clk);

    // Randomized traffic against the model.
    for (int seg = 0; seg < 10; seg++) begin
      int p;
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      sample_div  = 8'($urandom_range(0, 3));
      dwell_len   = 16'($urandom_range(0, 3));
      timeout_len = 16'($urandom_range(0, 8));
      p = $urandom_range(40, 98);
      enable = 1'b1;
      for (int c = 0; c < 300; c++) begin
        lock_in   = ($urandom_range(0, 99) < p);
        clear_err = ($urandom_range(0, 49) == 0);
        enable    = ($urandom_range(0, 199) != 0);
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
